// File: rtl/match_window_counter.sv
// match_window_counter: counts match pulses over fixed-length windows and hands each
// window's count to a consumer through a single-entry valid/ready report register.
module match_window_counter #(
  parameter int WINDOW_LEN = 64,
  parameter int CNT_W      = 8,
  parameter int THRESH     = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable,
  input  logic             match_in,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_sat,
  output logic             rpt_lost,
  output logic             alarm,
  output logic             busy
);
  localparam int TW = $clog2(WINDOW_LEN);
  localparam logic [TW-1:0] LAST = TW'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] PRE = CNT_W'(THRESH - 1);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             sat_q, sat_d, sat_nxt;
  logic             rpt_valid_q, rpt_valid_d;
  logic [CNT_W-1:0] rpt_count_q, rpt_count_d;
  logic             rpt_sat_q, rpt_sat_d;
  logic             rpt_lost_q, rpt_lost_d;
  logic             alarm_q, alarm_d;
  logic             counting, win_end, hit, restart;
  always_comb begin
    counting    = (state_q == COUNT) && enable;
    win_end     = counting && (timer_q == LAST);
    hit         = counting && match_in;
    restart     = !counting || win_end;
    cnt_inc     = cnt_q + CNT_W'(hit && (cnt_q != MAX));
    sat_nxt     = sat_q | (hit && (cnt_q == MAX));
    state_d     = enable ? COUNT : IDLE;
    timer_d     = restart ? '0 : timer_q + TW'(1);
    cnt_d       = restart ? '0 : cnt_inc;
    sat_d       = restart ? 1'b0 : sat_nxt;
    alarm_d     = hit && (cnt_q == PRE);
    // the window-end match belongs to the ending window, so the report takes cnt_inc
    rpt_valid_d = win_end | (rpt_valid_q & ~rpt_ready);
    rpt_count_d = win_end ? cnt_inc : rpt_count_q;
    rpt_sat_d   = win_end ? sat_nxt : rpt_sat_q;
    rpt_lost_d  = rpt_lost_q | (win_end & rpt_valid_q & ~rpt_ready);
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_count_q <= '0;
      rpt_sat_q   <= 1'b0;
      rpt_lost_q  <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_count_q <= rpt_count_d;
      rpt_sat_q   <= rpt_sat_d;
      rpt_lost_q  <= rpt_lost_d;
      alarm_q     <= alarm_d;
    end
  end
  assign busy      = (state_q == COUNT);
  assign rpt_valid = rpt_valid_q;
  assign rpt_count = rpt_count_q;
  assign rpt_sat   = rpt_sat_q;
  assign rpt_lost  = rpt_lost_q;
  assign alarm     = alarm_q;
endmodule
